// File: rtl/mem_access_ctrl_pkg.sv
// Shared opcodes, FSM state type and access-classification helpers for the
// CPU data-memory access controller.
package mem_access_ctrl_pkg;

  // MIPS load/store primary opcodes
  localparam logic [5:0] OPCODE_LB  = 6'h20;
  localparam logic [5:0] OPCODE_LH  = 6'h21;
  localparam logic [5:0] OPCODE_LWL = 6'h22;
  localparam logic [5:0] OPCODE_LW  = 6'h23;
  localparam logic [5:0] OPCODE_LBU = 6'h24;
  localparam logic [5:0] OPCODE_LHU = 6'h25;
  localparam logic [5:0] OPCODE_LWR = 6'h26;
  localparam logic [5:0] OPCODE_SB  = 6'h28;
  localparam logic [5:0] OPCODE_SH  = 6'h29;
  localparam logic [5:0] OPCODE_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_t;

  function automatic logic is_load(input logic [5:0] op);
    return op inside {OPCODE_LB, OPCODE_LBU, OPCODE_LH, OPCODE_LHU,
                      OPCODE_LW, OPCODE_LWL, OPCODE_LWR};
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op inside {OPCODE_SB, OPCODE_SH, OPCODE_SW};
  endfunction

  // Word accesses need lsb==0, halfword accesses an even address;
  // byte and LWL/LWR accesses can never fault.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] lsb);
    case (op)
      OPCODE_LW, OPCODE_SW:               return lsb != 2'b00;
      OPCODE_LH, OPCODE_LHU, OPCODE_SH:   return lsb[0];
      default:                            return 1'b0;
    endcase
  endfunction

  // Byte lanes read for each load flavour at byte offset lsb.
  function automatic logic [3:0] load_lanes(input logic [5:0] op, input logic [1:0] lsb);
    case (op)
      OPCODE_LB, OPCODE_LBU: return 4'b0001 << lsb;
      OPCODE_LH, OPCODE_LHU: return lsb[1] ? 4'b1100 : 4'b0011;
      OPCODE_LW:             return 4'b1111;
      OPCODE_LWL:            return 4'b1111 >> lsb;
      OPCODE_LWR:            return 4'b1111 << (2'd3 - lsb);
      default:               return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_lane_fmt.sv
// Store formatter: picks byte lanes and replicates rt across the data bus so
// the addressed lane always carries the right bytes.
module store_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_lsb,
  input  logic [31:0] i_rt,
  output logic [3:0]  o_byteenable,
  output logic [31:0] o_writedata
);

  // Lane select and data replication per store width
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    o_byteenable = 4'b0000;
    o_writedata  = 32'd0;
    case (i_opcode)
      OPCODE_SB: begin
        o_byteenable = 4'b0001 << i_lsb;
        o_writedata  = {4{i_rt[7:0]}};
      end
      OPCODE_SH: begin
        o_byteenable = i_lsb[1] ? 4'b1100 : 4'b0011;
        o_writedata  = {2{i_rt[15:0]}};
      end
      OPCODE_SW: begin
        o_byteenable = 4'b1111;
        o_writedata  = i_rt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: runs one CPU load/store at a time on an
// Avalon-style bus, waits out waitrequest, and returns merged/extended load
// data with a one-cycle done pulse.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err_misalign,
  output logic        err_timeout,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic        TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = TIMEOUT - 32'd1;

  mac_state_t  r_state, w_next;
  logic        w_accept, w_err_mis, w_err_tmo, w_bus_ok;

  logic [5:0]  r_opcode;
  logic [1:0]  r_lsb;
  logic [31:0] r_rt, r_rdata, r_load_data;
  logic [31:0] r_addr, r_wd;
  logic [3:0]  r_be;
  logic        r_read, r_write, r_busy, r_done, r_err_mis, r_err_tmo, r_rd_ok;
  logic [31:0] r_tmo_cnt;

  logic [3:0]  w_st_be;
  logic [31:0] w_st_wd, w_merged;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_deliver;

  store_lane_fmt u_store_lane_fmt (
    .i_opcode     (req_opcode),
    .i_lsb        (req_addr[1:0]),
    .i_rt         (req_rt),
    .o_byteenable (w_st_be),
    .o_writedata  (w_st_wd)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode and per-transition control strobes
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_err_mis = 1'b0;
    w_err_tmo = 1'b0;
    w_bus_ok  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (!is_load(req_opcode) && !is_store(req_opcode)) begin
            w_next = ST_DONE;
          end else if (is_misaligned(req_opcode, req_addr[1:0])) begin
            w_next    = ST_DONE;
            w_err_mis = 1'b1;
          end else if (is_load(req_opcode)) begin
            w_next = ST_READ;
          end else begin
            w_next = ST_WRITE;
          end
        end
      end
      ST_READ, ST_WRITE: begin
        if (!waitrequest) begin
          w_next   = ST_DONE;
          w_bus_ok = 1'b1;
        end else if (TMO_EN && (r_tmo_cnt == TMO_LAST)) begin
          w_next    = ST_DONE;
          w_err_tmo = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, bus drive, timeout counter and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode    <= 6'd0;
      r_lsb       <= 2'd0;
      r_rt        <= 32'd0;
      r_rdata     <= 32'd0;
      r_load_data <= 32'd0;
      r_addr      <= 32'd0;
      r_wd        <= 32'd0;
      r_be        <= 4'd0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_mis   <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_rd_ok     <= 1'b0;
      r_tmo_cnt   <= 32'd0;
    end else begin
      r_busy    <= (w_next != ST_IDLE);
      r_done    <= (w_next == ST_DONE);
      r_err_mis <= w_err_mis;
      r_err_tmo <= w_err_tmo;
      r_rd_ok   <= w_bus_ok && (r_state == ST_READ);

      if (w_accept) begin
        r_opcode <= req_opcode;
        r_lsb    <= req_addr[1:0];
        r_rt     <= req_rt;
      end

      // Bus outputs move only when a cycle is issued or when DONE is entered
      if (w_accept && (w_next == ST_READ)) begin
        r_read <= 1'b1;
        r_addr <= {req_addr[31:2], 2'b00};
        r_be   <= load_lanes(req_opcode, req_addr[1:0]);
      end else if (w_accept && (w_next == ST_WRITE)) begin
        r_write <= 1'b1;
        r_addr  <= {req_addr[31:2], 2'b00};
        r_be    <= w_st_be;
        r_wd    <= w_st_wd;
      end else if (w_next == ST_DONE) begin
        r_read  <= 1'b0;
        r_write <= 1'b0;
      end

      if (w_accept) begin
        r_tmo_cnt <= 32'd0;
      end else if (((r_state == ST_READ) || (r_state == ST_WRITE)) && waitrequest) begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end

      if ((r_state == ST_READ) && !waitrequest) r_rdata <= readdata;

      if (w_deliver) r_load_data <= w_merged;
    end
  end

  // Lane extraction, sign/zero extension and LWL/LWR merge with rt
  always_comb begin
    w_byte   = r_rdata[{r_lsb, 3'b000} +: 8];
    w_half   = r_lsb[1] ? r_rdata[31:16] : r_rdata[15:0];
    w_merged = r_rdata;
    case (r_opcode)
      OPCODE_LB:  w_merged = {{24{w_byte[7]}}, w_byte};
      OPCODE_LBU: w_merged = {24'd0, w_byte};
      OPCODE_LH:  w_merged = {{16{w_half[15]}}, w_half};
      OPCODE_LHU: w_merged = {16'd0, w_half};
      // Lanes that were read come from memory in place; the rest keep rt
      OPCODE_LWL, OPCODE_LWR: begin
        for (int i = 0; i < 4; i++) begin
          w_merged[8*i +: 8] = r_be[i] ? r_rdata[8*i +: 8] : r_rt[8*i +: 8];
        end
      end
      default: w_merged = r_rdata;
    endcase
  end

  // Fresh load result is shown during its done cycle, then held
  assign w_deliver    = (r_state == ST_DONE) && r_rd_ok;
  assign load_data    = w_deliver ? w_merged : r_load_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err_misalign = r_err_mis;
  assign err_timeout  = r_err_tmo;
  assign address      = r_addr;
  assign read         = r_read;
  assign write        = r_write;
  assign byteenable   = r_be;
  assign writedata    = r_wd;

endmodule
